// File: rtl/window_display_scan_pkg.sv
//------------------------------------------------------------------------------
// Module  : window_pkg
// Brief   : Shared defaults, character codes and glyph encoder for the
//           window_display_scan slice.
// Rev     : 1.0  initial release
//------------------------------------------------------------------------------
`default_nettype none

package window_pkg;

  localparam int c_msg_len    = 12;
  localparam int c_num_digits = 4;

  typedef logic [4:0] char_code_t;

  // Codes 0..9 are the decimal digits; letters and punctuation follow.
  localparam char_code_t c_ch_0     = 5'd0;
  localparam char_code_t c_ch_2     = 5'd2;
  localparam char_code_t c_ch_4     = 5'd4;
  localparam char_code_t c_ch_a     = 5'd10;
  localparam char_code_t c_ch_b     = 5'd11;
  localparam char_code_t c_ch_c     = 5'd12;
  localparam char_code_t c_ch_d     = 5'd13;
  localparam char_code_t c_ch_e     = 5'd14;
  localparam char_code_t c_ch_f     = 5'd15;
  localparam char_code_t c_ch_h     = 5'd16;
  localparam char_code_t c_ch_l     = 5'd17;
  localparam char_code_t c_ch_p     = 5'd18;
  localparam char_code_t c_ch_u     = 5'd19;
  localparam char_code_t c_ch_dash  = 5'd20;
  localparam char_code_t c_ch_blank = 5'd21;
  localparam char_code_t c_ch_undef = 5'd31;

  localparam logic [6:0] c_seg_blank = 7'b1111111;

  // Returns active-low {g,f,e,d,c,b,a}; codes without a glyph go blank.
  function automatic logic [6:0] encode_glyph(input char_code_t code);
    logic [6:0] lit;
    lit = 7'b0000000;
    case (code)
      5'd0:      lit = 7'b0111111;
      5'd1:      lit = 7'b0000110;
      5'd2:      lit = 7'b1011011;
      5'd3:      lit = 7'b1001111;
      5'd4:      lit = 7'b1100110;
      5'd5:      lit = 7'b1101101;
      5'd6:      lit = 7'b1111101;
      5'd7:      lit = 7'b0000111;
      5'd8:      lit = 7'b1111111;
      5'd9:      lit = 7'b1101111;
      c_ch_a:    lit = 7'b1110111;
      c_ch_b:    lit = 7'b1111100;
      c_ch_c:    lit = 7'b0111001;
      c_ch_d:    lit = 7'b1011110;
      c_ch_e:    lit = 7'b1111001;
      c_ch_f:    lit = 7'b1110001;
      c_ch_h:    lit = 7'b1110110;
      c_ch_l:    lit = 7'b0111000;
      c_ch_p:    lit = 7'b1110011;
      c_ch_u:    lit = 7'b0111110;
      c_ch_dash: lit = 7'b1000000;
      default:   lit = 7'b0000000;
    endcase
    return ~lit;
  endfunction

endpackage

`default_nettype wire

// File: rtl/window_display_scan_if.sv
//------------------------------------------------------------------------------
// Module  : window_display_scan_if
// Brief   : Control inputs and multiplexed 7-segment outputs of the scanner.
// Rev     : 1.0  initial release
//------------------------------------------------------------------------------
`default_nettype none

interface window_display_scan_if
  import window_pkg::*;
#(
  parameter int NUM_DIGITS = c_num_digits
);
  logic                  tick_refresh;
  logic                  display_en;
  logic [3:0]            win_idx;
  logic [NUM_DIGITS-1:0] an;
  logic [6:0]            seg;
  logic                  frame_start;

  modport master (
    output tick_refresh, display_en, win_idx,
    input  an, seg, frame_start
  );

  modport slave (
    input  tick_refresh, display_en, win_idx,
    output an, seg, frame_start
  );
endinterface

`default_nettype wire

// File: rtl/window_display_scan_msg_rom.sv
//------------------------------------------------------------------------------
// Module  : msg_rom
// Brief   : Combinational circular-message store, "HELL0-2024A" plus one
//           glyph-less code in the last slot.
// Rev     : 1.0  initial release
//------------------------------------------------------------------------------
`default_nettype none

module msg_rom
  import window_pkg::*;
#(
  parameter int MSG_LEN = c_msg_len
) (
  input  logic [4:0] addr_i,
  output char_code_t code_o
);

  localparam logic [4:0] c_len = 5'(MSG_LEN);

  always_comb begin
    code_o = c_ch_blank;
    case (addr_i)
      5'd0:    code_o = c_ch_h;
      5'd1:    code_o = c_ch_e;
      5'd2:    code_o = c_ch_l;
      5'd3:    code_o = c_ch_l;
      5'd4:    code_o = c_ch_0;
      5'd5:    code_o = c_ch_dash;
      5'd6:    code_o = c_ch_2;
      5'd7:    code_o = c_ch_0;
      5'd8:    code_o = c_ch_2;
      5'd9:    code_o = c_ch_4;
      5'd10:   code_o = c_ch_a;
      5'd11:   code_o = c_ch_undef;
      default: code_o = c_ch_blank;
    endcase
    if (addr_i >= c_len) begin
      code_o = c_ch_blank;
    end
  end

endmodule

`default_nettype wire

// File: rtl/window_display_scan.sv
//------------------------------------------------------------------------------
// Module  : window_display_scan
// Brief   : Two-stage digit scanner showing a sliding window of a circular
//           message. Define FRAME_LATCH_EN to hold the window per frame.
// Rev     : 1.0  initial release
//------------------------------------------------------------------------------
`default_nettype none

module window_display_scan
  import window_pkg::*;
#(
  parameter int MSG_LEN    = c_msg_len,
  parameter int NUM_DIGITS = c_num_digits
) (
  input  logic                   clk,
  input  logic                   rst,
  window_display_scan_if.slave   bus
);

  localparam int              DIG_W        = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
  localparam logic [DIG_W-1:0] c_last_digit = DIG_W'(NUM_DIGITS - 1);
  localparam logic [4:0]       c_len        = 5'(MSG_LEN);

  logic [DIG_W-1:0]      digit_q, digit_d;
  logic                  wrap_w;
  logic [3:0]            win_clean_w;
  logic [3:0]            base_w;
  logic [4:0]            sum_w, addr_d;
  logic                  s1_valid_q;
  logic [DIG_W-1:0]      s1_digit_q;
  logic [4:0]            s1_addr_q;
  char_code_t            code_w;
  logic [NUM_DIGITS-1:0] an_sel_w;
  logic [NUM_DIGITS-1:0] an_q;
  logic [6:0]            seg_q;
  logic                  frame_start_q;

  always_comb begin
    wrap_w      = (digit_q == c_last_digit);
    digit_d     = digit_q;
    if (bus.tick_refresh) begin
      digit_d = wrap_w ? '0 : digit_q + 1'b1;
    end
    win_clean_w = ({1'b0, bus.win_idx} >= c_len) ? 4'd0 : bus.win_idx;
  end

`ifdef FRAME_LATCH_EN
  logic [3:0] base_q, base_d;

  // The wrapping tick both latches the new window and addresses digit 0 with it.
  always_comb begin
    base_d = (bus.tick_refresh && wrap_w) ? win_clean_w : base_q;
    base_w = base_d;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) base_q <= 4'd0;
    else     base_q <= base_d;
  end
`else
  always_comb base_w = win_clean_w;
`endif

  always_comb begin
    sum_w  = {1'b0, base_w} + 5'(digit_d);
    addr_d = (sum_w >= c_len) ? sum_w - c_len : sum_w;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      digit_q    <= '0;
      s1_valid_q <= 1'b0;
      s1_digit_q <= '0;
      s1_addr_q  <= 5'd0;
    end else begin
      digit_q    <= digit_d;
      s1_valid_q <= bus.tick_refresh;
      if (bus.tick_refresh) begin
        s1_digit_q <= digit_d;
        s1_addr_q  <= addr_d;
      end
    end
  end

  msg_rom #(.MSG_LEN(MSG_LEN)) u_msg_rom (
    .addr_i (s1_addr_q),
    .code_o (code_w)
  );

  // Digit 0 sits on the MSB of an.
  for (genvar i = 0; i < NUM_DIGITS; i++) begin : g_an_sel
    assign an_sel_w[i] = (s1_digit_q != DIG_W'(NUM_DIGITS - 1 - i));
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      an_q          <= '1;
      seg_q         <= c_seg_blank;
      frame_start_q <= 1'b0;
    end else begin
      frame_start_q <= s1_valid_q && (s1_digit_q == '0);
      if (s1_valid_q) seg_q <= encode_glyph(code_w);
      if (!bus.display_en)  an_q <= '1;
      else if (s1_valid_q)  an_q <= an_sel_w;
    end
  end

  assign bus.an          = an_q;
  assign bus.seg         = seg_q;
  assign bus.frame_start = frame_start_q;

endmodule

`default_nettype wire

// File: tb/tb_window_display_scan.sv
//------------------------------------------------------------------------------
// Module  : tb_window_display_scan
// Brief   : Directed self-checking bench for window_display_scan.
// Rev     : 1.0  initial release
//------------------------------------------------------------------------------
`default_nettype none

module tb_window_display_scan;

  localparam logic [6:0] c_g_h  = 7'b0001001;
  localparam logic [6:0] c_g_e  = 7'b0000110;
  localparam logic [6:0] c_g_l  = 7'b1000111;
  localparam logic [6:0] c_g_0  = 7'b1000000;
  localparam logic [6:0] c_g_a  = 7'b0001000;
  localparam logic [6:0] c_g_2  = 7'b0100100;
  localparam logic [6:0] c_g_ds = 7'b0111111;
  localparam logic [6:0] c_g_bl = 7'b1111111;

  logic clk;
  logic rst;
  int   n_tests;
  int   n_fail;
  logic [3:0] prev_an;

  window_display_scan_if #(.NUM_DIGITS(4)) bus ();

  window_display_scan #(.MSG_LEN(12), .NUM_DIGITS(4)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Tick on a negedge; outputs must be unchanged one edge later and updated two edges later.
  task automatic do_tick(input string tag, input logic [3:0] exp_an, input logic [6:0] exp_seg,
                         input logic exp_fs, input logic chk_seg);
    @(negedge clk) bus.tick_refresh = 1'b1;
    @(negedge clk) bus.tick_refresh = 1'b0;
    check({tag, "_hold"}, 32'(bus.an), 32'(prev_an));
    @(negedge clk);
    check({tag, "_an"}, 32'(bus.an), 32'(exp_an));
    check({tag, "_fs"}, 32'(bus.frame_start), 32'(exp_fs));
    if (chk_seg) check({tag, "_seg"}, 32'(bus.seg), 32'(exp_seg));
    prev_an = exp_an;
  endtask

  initial begin
    n_tests          = 0;
    n_fail           = 0;
    prev_an          = 4'hF;
    rst              = 1'b1;
    bus.tick_refresh = 1'b0;
    bus.display_en   = 1'b1;
    bus.win_idx      = 4'd0;
    repeat (3) @(negedge clk);
    rst = 1'b0;

    // Reset state holds without ticks
    repeat (5) @(negedge clk);
    check("rst_an",  32'(bus.an), 32'h0000000F);
    check("rst_seg", 32'(bus.seg), 32'h0000007F);
    check("rst_fs",  32'(bus.frame_start), 32'h0);
    repeat (10) @(negedge clk);
    check("idle_an", 32'(bus.an), 32'h0000000F);
    check("idle_fs", 32'(bus.frame_start), 32'h0);

    // win_idx 0: first tick shows digit 1
    do_tick("w0_d1", 4'b1011, c_g_e, 1'b0, 1'b1);
    do_tick("w0_d2", 4'b1101, c_g_l, 1'b0, 1'b1);
    do_tick("w0_d3", 4'b1110, c_g_l, 1'b0, 1'b1);
    do_tick("w0_d0", 4'b0111, c_g_h, 1'b1, 1'b1);
    @(negedge clk);
    check("w0_fs_one_cycle", 32'(bus.frame_start), 32'h0);

    // win_idx 10 wraps: addresses 11,0,1,10
    bus.win_idx = 4'd10;
    do_tick("w10_fl1", 4'b1011, c_g_bl, 1'b0, 1'b0);
    do_tick("w10_fl2", 4'b1101, c_g_bl, 1'b0, 1'b0);
    do_tick("w10_fl3", 4'b1110, c_g_bl, 1'b0, 1'b0);
    do_tick("w10_fl0", 4'b0111, c_g_a,  1'b1, 1'b1);
    do_tick("w10_d1",  4'b1011, c_g_bl, 1'b0, 1'b1);
    do_tick("w10_d2",  4'b1101, c_g_h,  1'b0, 1'b1);
    do_tick("w10_d3",  4'b1110, c_g_e,  1'b0, 1'b1);
    do_tick("w10_d0",  4'b0111, c_g_a,  1'b1, 1'b1);

    // Out-of-range window behaves as 0
    bus.win_idx = 4'd15;
    do_tick("w15_fl1", 4'b1011, c_g_bl, 1'b0, 1'b0);
    do_tick("w15_fl2", 4'b1101, c_g_bl, 1'b0, 1'b0);
    do_tick("w15_fl3", 4'b1110, c_g_bl, 1'b0, 1'b0);
    do_tick("w15_fl0", 4'b0111, c_g_h,  1'b1, 1'b1);
    do_tick("w15_d1",  4'b1011, c_g_e,  1'b0, 1'b1);
    do_tick("w15_d2",  4'b1101, c_g_l,  1'b0, 1'b1);
    do_tick("w15_d3",  4'b1110, c_g_l,  1'b0, 1'b1);
    do_tick("w15_d0",  4'b0111, c_g_h,  1'b1, 1'b1);

    // Window moves 2 -> 3 mid-frame
    bus.win_idx = 4'd2;
    do_tick("mv_fl1", 4'b1011, c_g_bl, 1'b0, 1'b0);
    do_tick("mv_fl2", 4'b1101, c_g_bl, 1'b0, 1'b0);
    do_tick("mv_fl3", 4'b1110, c_g_bl, 1'b0, 1'b0);
    do_tick("mv_fl0", 4'b0111, c_g_l,  1'b1, 1'b1);
    do_tick("mv_d1",  4'b1011, c_g_l,  1'b0, 1'b1);
    bus.win_idx = 4'd3;
`ifdef FRAME_LATCH_EN
    do_tick("mv_d2",  4'b1101, c_g_0,  1'b0, 1'b1);
    do_tick("mv_d3",  4'b1110, c_g_ds, 1'b0, 1'b1);
`else
    do_tick("mv_d2",  4'b1101, c_g_ds, 1'b0, 1'b1);
    do_tick("mv_d3",  4'b1110, c_g_2,  1'b0, 1'b1);
`endif
    do_tick("mv_d0",  4'b0111, c_g_l,  1'b1, 1'b1);
    do_tick("mv_n1",  4'b1011, c_g_0,  1'b0, 1'b1);
    do_tick("mv_n2",  4'b1101, c_g_ds, 1'b0, 1'b1);
    do_tick("mv_n3",  4'b1110, c_g_2,  1'b0, 1'b1);
    do_tick("mv_n0",  4'b0111, c_g_l,  1'b1, 1'b1);

    // Blank for one frame, scan and frame_start keep running
    bus.win_idx    = 4'd0;
    bus.display_en = 1'b0;
    @(negedge clk);
    @(negedge clk);
    check("dis_an_now", 32'(bus.an), 32'h0000000F);
    prev_an = 4'hF;
`ifdef FRAME_LATCH_EN
    do_tick("dis_d1", 4'b1111, c_g_bl, 1'b0, 1'b0);
    do_tick("dis_d2", 4'b1111, c_g_bl, 1'b0, 1'b0);
    do_tick("dis_d3", 4'b1111, c_g_bl, 1'b0, 1'b0);
`else
    do_tick("dis_d1", 4'b1111, c_g_e,  1'b0, 1'b1);
    do_tick("dis_d2", 4'b1111, c_g_l,  1'b0, 1'b1);
    do_tick("dis_d3", 4'b1111, c_g_l,  1'b0, 1'b1);
`endif
    do_tick("dis_d0", 4'b1111, c_g_h,  1'b1, 1'b1);
    bus.display_en = 1'b1;
    do_tick("en_d1",  4'b1011, c_g_e,  1'b0, 1'b1);

    // Reset lands between a tick and its stage-2 update
    @(negedge clk) bus.tick_refresh = 1'b1;
    @(negedge clk) begin
      bus.tick_refresh = 1'b0;
      rst = 1'b1;
    end
    #1;
    check("mrst_an_imm", 32'(bus.an), 32'h0000000F);
    @(negedge clk);
    check("mrst_an",  32'(bus.an), 32'h0000000F);
    check("mrst_seg", 32'(bus.seg), 32'h0000007F);
    check("mrst_fs",  32'(bus.frame_start), 32'h0);
    rst = 1'b0;
    repeat (4) @(negedge clk);
    check("mrst_stale_an",  32'(bus.an), 32'h0000000F);
    check("mrst_stale_seg", 32'(bus.seg), 32'h0000007F);
    prev_an = 4'hF;
    do_tick("post_rst_d1", 4'b1011, c_g_e, 1'b0, 1'b1);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/window_display_scan.md
WINDOW_DISPLAY_SCAN -- requirements
Module: window_display_scan

Interface
REQ-001 Parameter: MSG_LEN, 12, number of characters in the circular message.
REQ-002 Parameter: NUM_DIGITS, 4, number of multiplexed 7-segment digits, 1..MSG_LEN.
REQ-003 Port: clk  input  1  single system clock; all state on rising edge.
REQ-004 Port: rst  input  1  reset, asynchronous, active-high.
REQ-005 Port: tick_refresh  input  1  one-cycle strobe; advances digit scan.
REQ-006 Port: display_en  input  1  high = drive display, low = blank all digits.
REQ-007 Port: win_idx  input  4  message index of leftmost visible character, from the window counter.
REQ-008 Port: an  output  NUM_DIGITS  digit enables, active-low, one-hot-low when displaying.
REQ-009 Port: seg  output  7  segments {g,f,e,d,c,b,a}, active-low.
REQ-010 Port: frame_start  output  1  one-cycle pulse when the scan begins digit 0.

Function
REQ-011 Digit counter SHALL advance 0..NUM_DIGITS-1 by one on each tick_refresh, wrapping NUM_DIGITS-1 -> 0.
REQ-012 Stage 1 SHALL register digit d and address (base + d) mod MSG_LEN on the cycle after the tick; sum computed 5 bits wide, MSG_LEN subtracted once if >= MSG_LEN.
REQ-013 Stage 2 SHALL register seg = encode(rom[address]) and an = all ones except bit d low; an/seg change together exactly 2 clocks after the tick.
REQ-014 Digit 0 SHALL be the leftmost digit (an MSB); digit d shows message character base+d.
REQ-015 win_idx >= MSG_LEN SHALL be treated as 0.
REQ-016 Character codes without a defined glyph SHALL encode to blank (seg all ones).
REQ-017 display_en low SHALL force an to all ones at stage 2 while scan and pipeline continue; re-enabling resumes with no extra latency.
REQ-018 frame_start SHALL pulse for one cycle coincident with the stage-2 update that drives digit 0.
REQ-019 tick_refresh while the pipeline is busy SHALL be accepted; each tick produces exactly one stage-2 update.

Reset
REQ-020 Reset SHALL set digit counter 0, base 0, an all ones, seg all ones, frame_start 0, pipeline valids 0.
REQ-021 Reset asserted mid-scan SHALL take effect immediately; first post-reset tick displays digit 1 (counter advances from 0).

Configuration
REQ-022 Macro FRAME_LATCH_EN defined: base SHALL be captured from win_idx only on the tick that wraps the counter to 0, so a frame never mixes two window positions.
REQ-023 FRAME_LATCH_EN undefined: base SHALL equal win_idx directly each cycle; no latch register.

Structure
REQ-024 Shared package window_pkg SHALL hold MSG_LEN default, NUM_DIGITS default, the 5-bit character-code type and named code constants, and the blank segment constant.
REQ-025 Message storage SHALL be a sub-module msg_rom: 5-bit address in, 5-bit code out, combinational, MSG_LEN entries.
REQ-026 Glyph encoding SHALL be a function in window_pkg, not a separate module.

Verification
REQ-027 Reset, no ticks -> an=1111, seg=1111111, frame_start=0 indefinitely.
REQ-028 win_idx=0, four ticks -> an sequence 1011,1101,1110,0111 each 2 clocks after its tick; glyphs for rom[1],rom[2],rom[3],rom[0].
REQ-029 win_idx=10, full frame -> addresses 10,11,0,1 (wrap-around); win_idx=15 -> addresses 0..3.
REQ-030 FRAME_LATCH_EN: change win_idx 2->3 on digit 2 tick -> remaining digits use base 2; next frame uses 3. Without macro: digit 3 uses base 3.
REQ-031 display_en low for one frame -> an=1111 throughout, frame_start still pulses; high again -> next update drives correct digit.
REQ-032 Assert rst between tick and stage-2 update -> outputs return to reset values, no stale update appears afterwards.
